// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one capture into a ring-addressed sample buffer.
// It stores pre-trigger samples, arms the external trigger block and waits
// for a hit while writing in a ring. It then stores the post-trigger samples
// and parks in DONE so that the buffer can be read out.
// Optional feature: define CAPTURE_TIMEOUT_EN to add a WAIT-state timeout.
// The timeout forces a trigger once timeout_limit WAIT cycles have elapsed.
module capture_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              sample_valid,
    input  logic              trig_triggered,
    input  logic              trig_armed,
`ifdef CAPTURE_TIMEOUT_EN
    input  logic [31:0]       timeout_limit,
    output logic              timed_out,
`endif
    output logic              trig_arm,
    output logic              trig_abort,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ARM  = 3'd2,
        WAIT = 3'd3,
        POST = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pre_lat;
    logic [ADDR_W-1:0] post_lat;
    logic [ADDR_W-1:0] write_cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              active;
    logic              timeout_hit;
    logic              trigger_hit;

    // trig_armed is status only; the FSM never waits on it.
    logic              unused_armed;
    assign unused_armed = trig_armed;

    // The write path follows the state and the current sample.
    // An abort kills the write in the same cycle.
    assign active   = (state == PRE) || (state == ARM) ||
                      (state == WAIT) || (state == POST);
    assign buf_we   = active && sample_valid && !abort;
    assign cnt_next = write_cnt + 1'b1;

`ifdef CAPTURE_TIMEOUT_EN
    logic [31:0] wait_cycles;

    // A zero limit disables the timeout.
    // Once expired, the next valid WAIT sample is the trigger.
    assign timeout_hit = (timeout_limit != 32'd0) && (wait_cycles >= timeout_limit);
`else
    assign timeout_hit = 1'b0;
`endif

    assign trigger_hit = trig_triggered || timeout_hit;

    // Capture sequencer: state, addresses, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            buf_addr   <= '0;
            trig_addr  <= '0;
            pre_lat    <= '0;
            post_lat   <= '0;
            write_cnt  <= '0;
            trig_arm   <= 1'b0;
            trig_abort <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
            wait_cycles <= '0;
            timed_out   <= 1'b0;
`endif
        end else begin
            trig_arm   <= 1'b0;
            trig_abort <= 1'b0;

            // Every accepted write advances the ring address.
            // The natural ADDR_W-bit overflow gives the wrap to zero.
            if (buf_we) begin
                buf_addr <= buf_addr + 1'b1;
            end

            if (active && abort) begin
                // Abort beats any trigger or start seen in the same cycle.
                state      <= IDLE;
                trig_abort <= 1'b1;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            // The latch is exactly ADDR_W bits wide.
                            // pre_count therefore cannot exceed the top address.
                            pre_lat   <= pre_count;
                            post_lat  <= post_count;
                            buf_addr  <= '0;
                            write_cnt <= '0;
                            done      <= 1'b0;
                            busy      <= 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
                            timed_out <= 1'b0;
`endif
                            if (pre_count == '0) begin
                                state    <= ARM;
                                trig_arm <= 1'b1;
                            end else begin
                                state <= PRE;
                            end
                        end
                    end

                    PRE: begin
                        if (sample_valid) begin
                            if (cnt_next == pre_lat) begin
                                state    <= ARM;
                                trig_arm <= 1'b1;
                            end else begin
                                write_cnt <= cnt_next;
                            end
                        end
                    end

                    ARM: begin
                        state     <= WAIT;
                        write_cnt <= '0;
`ifdef CAPTURE_TIMEOUT_EN
                        wait_cycles <= '0;
`endif
                    end

                    WAIT: begin
                        if (sample_valid && trigger_hit) begin
                            trig_addr <= buf_addr;
                            write_cnt <= '0;
`ifdef CAPTURE_TIMEOUT_EN
                            if (!trig_triggered) begin
                                timed_out <= 1'b1;
                            end
`endif
                            if (post_lat == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= POST;
                            end
                        end else begin
`ifdef CAPTURE_TIMEOUT_EN
                            if (wait_cycles != 32'hFFFF_FFFF) begin
                                wait_cycles <= wait_cycles + 32'd1;
                            end
`endif
                        end
                    end

                    POST: begin
                        if (sample_valid) begin
                            if (cnt_next == post_lat) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                write_cnt <= cnt_next;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
